// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for input_debouncer.
//   state_e      - 2-bit debouncer state encoding
//   cnt_width()  - width of a counter that can hold 0..n
//   GLITCH_CNT_W - width of the optional aborted-check counter
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_e;

    localparam int GLITCH_CNT_W = 8;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: SYNC_STAGES-deep flop synchroniser for an asynchronous 1-bit pin.
//   clk - sampling clock
//   rst - asynchronous active-low reset, loads RESET_VAL into every stage
//   d   - asynchronous input
//   q   - synchronised output
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain_q <= {SYNC_STAGES{RESET_VAL}};
        else      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises and debounces a raw pin, with edge strobes.
//   clk        - single clock
//   rst        - asynchronous active-low reset
//   raw        - unsynchronised input
//   clean      - debounced level (registered)
//   rise/fall  - one-cycle strobes when clean changes 0->1 / 1->0
//   busy       - high while a new level is being qualified
//   glitch_cnt - saturating count of aborted checks (only with GLITCH_CNT_EN)
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam int     CNT_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam state_e RST_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

    logic             s, last, abort;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(RESET_VAL)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (raw),
        .q  (s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // The sample that reaches DEBOUNCE_CYCLES-1 plus the current one completes the run.
    assign last = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        abort   = 1'b0;
        case (state_q)
            STABLE_LO: begin
                state_d = s ? CHECK_HI : STABLE_LO;
                cnt_d   = s ? CNT_W'(1) : '0;
            end
            CHECK_HI: begin
                state_d = !s ? STABLE_LO : last ? STABLE_HI : CHECK_HI;
                cnt_d   = (s && !last) ? cnt_q + CNT_W'(1) : '0;
                abort   = !s;
            end
            STABLE_HI: begin
                state_d = !s ? CHECK_LO : STABLE_HI;
                cnt_d   = !s ? CNT_W'(1) : '0;
            end
            default: begin
                state_d = s ? STABLE_HI : last ? STABLE_LO : CHECK_LO;
                cnt_d   = (!s && !last) ? cnt_q + CNT_W'(1) : '0;
                abort   = s;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in the same edge as the state change.
    always_comb begin
        clean_d = (state_d == STABLE_HI) || (state_d == CHECK_LO);
        rise_d  = (state_q == CHECK_HI) && (state_d == STABLE_HI);
        fall_d  = (state_q == CHECK_LO) && (state_d == STABLE_LO);
        busy_d  = (state_d == CHECK_HI) || (state_d == CHECK_LO);
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign busy  = busy_q;

`ifdef GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          glitch_q <= '0;
        else if (abort && glitch_q != '1)  glitch_q <= glitch_q + GLITCH_CNT_W'(1);
    end

    assign glitch_cnt = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed, table-driven bench for input_debouncer (defaults).
module tb_input_debouncer;

    typedef struct packed {
        logic       raw;
        logic [3:0] exp;
    } vec_t;

    logic       clk, rst, raw, clean, rise, fall, busy;
    logic [3:0] o;
    int         total = 0;
    int         passed = 0;
    vec_t       tbl[$];
`ifdef GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    input_debouncer dut (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw),
        .clean(clean),
        .rise (rise),
        .fall (fall),
        .busy (busy)
`ifdef GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    assign o = {clean, rise, fall, busy};

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic v(input int n, input logic r, input logic [3:0] e);
        for (int i = 0; i < n; i++) tbl.push_back('{raw: r, exp: e});
    endtask

    initial begin
        int at;
        // {clean, rise, fall, busy} after each edge; raw is applied just before that edge
        v(2, 1, 4'b0000); v(3, 1, 4'b0001); v(1, 1, 4'b1100); v(2, 1, 4'b1000);
        v(2, 0, 4'b1000); v(2, 1, 4'b1001); v(2, 1, 4'b1000);
        v(2, 0, 4'b1000); v(3, 0, 4'b1001); v(1, 0, 4'b0010); v(1, 0, 4'b0000);
        v(2, 1, 4'b0000); v(1, 1, 4'b0001);
        v(2, 0, 4'b0001); v(2, 0, 4'b0000);
        v(2, 1, 4'b0000); v(2, 1, 4'b0001);
        v(1, 0, 4'b0001); v(1, 0, 4'b1100); v(3, 0, 4'b1001); v(1, 0, 4'b0010); v(1, 0, 4'b0000);

        rst = 1'b0;
        raw = 1'b1;
        #1 check("reset_async", 8'(o), 8'h0);
        #14 check("reset_hold", 8'(o), 8'h0);
        #7;
        rst = 1'b1;
        raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_low", 8'(o), 8'h0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            raw = tbl[i].raw;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i + 1), 8'(o), 8'(tbl[i].exp));
        end
`ifdef GLITCH_CNT_EN
        check("glitch_after_table", glitch_cnt, 8'd2);
`endif

        raw = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("midcheck_busy", 8'(o), 8'h1);
        #2 rst = 1'b0;
        #1 check("midcheck_abort", 8'(o), 8'h0);
        raw = 1'b0;
        @(posedge clk); #1;
        check("reset_held", 8'(o), 8'h0);
`ifdef GLITCH_CNT_EN
        check("glitch_reset", glitch_cnt, 8'd0);
`endif
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_abort", 8'(o), 8'h0);
        end

        for (int i = 0; i < 20; i++) begin
            raw = ((i / 2) % 2) == 0;
            @(posedge clk); #1;
            check("chatter", 8'(o[3:1]), 8'h0);
        end
        raw = 1'b1;
        at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (at == 0 && clean) begin
                at = i;
                check("chatter_rise_pulse", 8'(rise), 8'h1);
            end
        end
        check("chatter_latency", 8'(at), 8'd6);
        check("chatter_settled", 8'(o), 8'h8);
`ifdef GLITCH_CNT_EN
        check("glitch_chatter", glitch_cnt, 8'd5);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
